node_pkt_tx: RTL and testbench

Transmit-side packet builder for a sensor node in the EER-RL clustering protocol. It is the counterpart of the node-info receive path. On a single request it snapshots the node's state (ID, hops, Q-value, energy, role, cluster head, timeslot) and serialises one protocol packet as 16-bit words onto a valid/ready stream toward the radio/MAC.

---
 rtl/node_pkt_pkg.sv | 60 ++++++
 rtl/node_pkt_tx_if.sv | 10 +
 rtl/node_pkt_word_mux.sv | 59 +++++
 rtl/node_pkt_tx.sv | 109 ++++++++++
 tb/tb_node_pkt_tx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/node_pkt_pkg.sv
// Shared definitions for EER-RL node packets: type codes, lengths and header layout.
// Imported by both the transmit builder and the receive-side node-info path.
package node_pkt_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_JREQ = 3'b010;
    localparam logic [2:0] PKT_TS   = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;
    localparam logic [2:0] PKT_SOS  = 3'b110;

    // Total words per packet, header included.
    localparam logic [7:0] LEN_HB   = 8'd4;
    localparam logic [7:0] LEN_CHE  = 8'd5;
    localparam logic [7:0] LEN_JREQ = 8'd5;
    localparam logic [7:0] LEN_TS   = 8'd4;
    localparam logic [7:0] LEN_DATA = 8'd5;
    localparam logic [7:0] LEN_SOS  = 8'd4;

    localparam int HDR_TYPE_MSB = 15;
    localparam int HDR_TYPE_LSB = 13;
    localparam int HDR_ROLE_BIT = 12;
    localparam int HDR_LOWE_BIT = 11;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 0;

    typedef enum logic {S_IDLE, S_SEND} tx_state_e;

    typedef struct packed {
        logic [2:0]  pkt_type;
        logic        role;
        logic        low_e;
        logic [15:0] node_id;
        logic [15:0] hops;
        logic [15:0] qval;
        logic [15:0] energy;
        logic [15:0] ch_id;
        logic [15:0] timeslot;
        logic [15:0] dst_id;
        logic [15:0] data;
    } pkt_snap_t;

    // Zero length marks the reserved codes 011 and 111.
    function automatic logic [7:0] pkt_len(input logic [2:0] t);
        case (t)
            PKT_HB:   return LEN_HB;
            PKT_CHE:  return LEN_CHE;
            PKT_JREQ: return LEN_JREQ;
            PKT_TS:   return LEN_TS;
            PKT_DATA: return LEN_DATA;
            PKT_SOS:  return LEN_SOS;
            default:  return 8'd0;
        endcase
    endfunction

    function automatic logic pkt_type_valid(input logic [2:0] t);
        return pkt_len(t) != 8'd0;
    endfunction

endpackage

// File: rtl/node_pkt_tx_if.sv
// Word stream from the packet builder toward the radio/MAC (valid/ready).
interface node_pkt_tx_if;
    logic [15:0] tx_word;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (output tx_word, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_word, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/node_pkt_word_mux.sv
// Selects the packet word for a given index from the snapshotted node state.
module node_pkt_word_mux
    import node_pkt_pkg::*;
#(
    parameter logic [15:0] BCAST_ID = 16'hFFFF,
    parameter logic [15:0] SINK_ID  = 16'h0000,
    parameter logic [15:0] HOP_MAX  = 16'hFFFF
) (
    input  pkt_snap_t   snap_i,
    input  logic [2:0]  idx_i,
    output logic [15:0] word_o,
    output logic        last_o
);

    logic [7:0]  len;
    logic [15:0] hops_fwd;
    logic [15:0] dst;
    logic [15:0] w3;
    logic [15:0] w4;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        len      = pkt_len(snap_i.pkt_type);
        hops_fwd = (snap_i.hops >= HOP_MAX) ? HOP_MAX : snap_i.hops + 16'd1;
        dst      = BCAST_ID;
        w3       = '0;
        w4       = '0;
        case (snap_i.pkt_type)
            PKT_HB:   w3 = hops_fwd;
            PKT_CHE:  begin w3 = snap_i.qval; w4 = snap_i.energy; end
            PKT_JREQ: begin dst = snap_i.ch_id; w3 = snap_i.qval; w4 = snap_i.energy; end
            PKT_TS:   begin dst = snap_i.dst_id; w3 = snap_i.timeslot; end
            PKT_DATA: begin
                dst = snap_i.role ? SINK_ID : snap_i.ch_id;
                w3  = snap_i.hops;
                w4  = snap_i.data;
            end
            PKT_SOS:  w3 = snap_i.energy;
            default:  ;
        endcase

        word_o = '0;
        case (idx_i)
            3'd0: begin
                word_o[HDR_TYPE_MSB:HDR_TYPE_LSB] = snap_i.pkt_type;
                word_o[HDR_ROLE_BIT]              = snap_i.role;
                word_o[HDR_LOWE_BIT]              = snap_i.low_e;
                word_o[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
            end
            3'd1:    word_o = snap_i.node_id;
            3'd2:    word_o = dst;
            3'd3:    word_o = w3;
            3'd4:    word_o = w4;
            default: word_o = '0;
        endcase
        last_o = ({5'b0, idx_i} == len - 8'd1);
    end

endmodule

// File: rtl/node_pkt_tx.sv
// Transmit-side packet builder: snapshots node state on request and streams
// one protocol packet as 16-bit words.
module node_pkt_tx
    import node_pkt_pkg::*;
#(
    parameter logic [15:0] BCAST_ID = 16'hFFFF,
    parameter logic [15:0] SINK_ID  = 16'h0000,
    parameter logic [15:0] HOP_MAX  = 16'hFFFF
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          tx_req,
    input  logic [2:0]    tx_pkt_type,
    output logic          req_ack,
    input  logic [15:0]   myNodeID,
    input  logic [15:0]   hopsFromSink,
    input  logic [15:0]   myQValue,
    input  logic [15:0]   energy,
    input  logic [15:0]   ch_ID,
    input  logic [15:0]   timeslot,
    input  logic [15:0]   dst_id,
    input  logic [15:0]   data_in,
    input  logic          role,
    input  logic          low_E,
    node_pkt_tx_if.master tx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    tx_state_e   state_q;
    logic [2:0]  idx_q;
    pkt_snap_t   snap_q;
    pkt_snap_t   snap_d;
    logic        valid_q;
    logic        err_q;
    logic [15:0] word;
    logic        last;
    logic        accept;

    always_comb begin
        snap_d = '{pkt_type: tx_pkt_type, role: role, low_e: low_E,
                   node_id: myNodeID, hops: hopsFromSink, qval: myQValue,
                   energy: energy, ch_id: ch_ID, timeslot: timeslot,
                   dst_id: dst_id, data: data_in};
    end

    node_pkt_word_mux #(
        .BCAST_ID (BCAST_ID),
        .SINK_ID  (SINK_ID),
        .HOP_MAX  (HOP_MAX)
    ) u_word_mux (
        .snap_i (snap_q),
        .idx_i  (idx_q),
        .word_o (word),
        .last_o (last)
    );

    assign accept = nrst && (state_q == S_IDLE) && tx_req && pkt_type_valid(tx_pkt_type);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            // NOTE: the snapshot is cleared too, so nothing from an aborted packet survives reset.
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_req) begin
                        if (pkt_type_valid(tx_pkt_type)) begin
                            snap_q  <= snap_d;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= S_SEND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (tx.tx_ready) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Word and last are gated so the idle bus reads zero rather than stale snapshot data.
    assign tx.tx_valid = valid_q;
    assign tx.tx_word  = valid_q ? word : '0;
    assign tx.tx_last  = valid_q & last;
    assign req_ack     = accept;
    assign busy        = (state_q == S_SEND);
    assign done        = nrst && valid_q && last && tx.tx_ready;
    assign err         = err_q;

endmodule

// File: tb/tb_node_pkt_tx.sv
// Scoreboard bench for node_pkt_tx: feature tasks push expected words,
// a negedge monitor pops and compares every transfer.
module tb_node_pkt_tx;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        tx_req = 1'b0;
    logic [2:0]  tx_pkt_type = 3'b000;
    logic        req_ack;
    logic [15:0] myNodeID = 16'h000C;
    logic [15:0] hopsFromSink = 16'h0003;
    logic [15:0] myQValue = 16'h0000;
    logic [15:0] energy = 16'h0000;
    logic [15:0] ch_ID = 16'h0000;
    logic [15:0] timeslot = 16'h0000;
    logic [15:0] dst_id = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic        role = 1'b0;
    logic        low_E = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    node_pkt_tx_if tx_if ();

    node_pkt_tx dut (
        .clk          (clk),
        .nrst         (nrst),
        .tx_req       (tx_req),
        .tx_pkt_type  (tx_pkt_type),
        .req_ack      (req_ack),
        .myNodeID     (myNodeID),
        .hopsFromSink (hopsFromSink),
        .myQValue     (myQValue),
        .energy       (energy),
        .ch_ID        (ch_ID),
        .timeslot     (timeslot),
        .dst_id       (dst_id),
        .data_in      (data_in),
        .role         (role),
        .low_E        (low_E),
        .tx           (tx_if),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   xfer_cnt = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_word = '0;
    logic        prev_last = 1'b0;

    // Reference packet model built directly from the protocol description.
    function automatic void push_pkt(input logic [2:0] t);
        logic [15:0] w[5];
        logic [15:0] hf;
        int          n;
        for (int i = 0; i < 5; i++) w[i] = '0;
        hf = (hopsFromSink == 16'hFFFF) ? 16'hFFFF : hopsFromSink + 16'd1;
        n  = 4;
        case (t)
            3'b000: begin n = 4; w[2] = 16'hFFFF; w[3] = hf; end
            3'b001: begin n = 5; w[2] = 16'hFFFF; w[3] = myQValue; w[4] = energy; end
            3'b010: begin n = 5; w[2] = ch_ID; w[3] = myQValue; w[4] = energy; end
            3'b100: begin n = 4; w[2] = dst_id; w[3] = timeslot; end
            3'b101: begin n = 5; w[2] = role ? 16'h0000 : ch_ID; w[3] = hopsFromSink; w[4] = data_in; end
            default: begin n = 4; w[2] = 16'hFFFF; w[3] = energy; end
        endcase
        w[0] = {t, role, low_E, 3'b000, 8'(n)};
        w[1] = myNodeID;
        for (int i = 0; i < n; i++) sb.push_back('{w: w[i], last: (i == n - 1)});
    endfunction

    always @(negedge clk) begin
        if (nrst) begin
            if (prev_stall) begin
                checks++;
                if (tx_if.tx_valid !== 1'b1 || tx_if.tx_word !== prev_word || tx_if.tx_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b word=%h last=%b, required valid=1 word=%h last=%b",
                             tx_if.tx_valid, tx_if.tx_word, tx_if.tx_last, prev_word, prev_last);
                end
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                xfer_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h with nothing expected", tx_if.tx_word);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (tx_if.tx_word !== e.w || tx_if.tx_last !== e.last || done !== e.last) begin
                        errors++;
                        $display("FAIL xfer_word: word=%h last=%b done=%b, required word=%h last=%b done=%b",
                                 tx_if.tx_word, tx_if.tx_last, done, e.w, e.last, e.last);
                    end
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_without_xfer: done=%b, required 0", done);
                end
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_word  = tx_if.tx_word;
            prev_last  = tx_if.tx_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle request; reports req_ack and tx_valid seen in that cycle.
    task automatic do_req(input logic [2:0] t, output logic ack, output logic vld);
        step();
        tx_req      = 1'b1;
        tx_pkt_type = t;
        @(negedge clk);
        ack = req_ack;
        vld = tx_if.tx_valid;
        step();
        tx_req = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy && sb.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tx_req = 1'b1;
        tx_pkt_type = 3'b000;
        tx_if.tx_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({tx_if.tx_valid, tx_if.tx_last, busy, done, err, req_ack} !== 6'b0 || tx_if.tx_word !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b last=%b busy=%b done=%b err=%b ack=%b word=%h, required all 0",
                     tx_if.tx_valid, tx_if.tx_last, busy, done, err, req_ack, tx_if.tx_word);
        end
        step();
        tx_req = 1'b0;
        nrst = 1'b1;
        step();
    endtask

    task automatic test_hb();
        logic ack, vld;
        bit   to;
        int   c0;
        myNodeID = 16'h000C; hopsFromSink = 16'h0003; role = 1'b0; low_E = 1'b0;
        tx_if.tx_ready = 1'b1;
        push_pkt(3'b000);
        c0 = xfer_cnt;
        do_req(3'b000, ack, vld);
        checks++;
        if (ack !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL hb_ack: ack=%b valid=%b, required ack=1 valid=0", ack, vld);
        end
        @(negedge clk);
        checks++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_word !== 16'h0004 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hb_first_word: valid=%b word=%h busy=%b, required 1 0004 1",
                     tx_if.tx_valid, tx_if.tx_word, busy);
        end
        wait_idle(20, to);
        checks++;
        if (to || xfer_cnt - c0 != 4) begin
            errors++;
            $display("FAIL hb_count: timeout=%0d xfers=%0d, required 0 and 4", to, xfer_cnt - c0);
        end
    endtask

    task automatic test_data();
        logic ack, vld;
        bit   to;
        hopsFromSink = 16'h0002; data_in = 16'hABCD; low_E = 1'b1; ch_ID = 16'h0007;
        for (int r = 1; r >= 0; r--) begin
            role = r[0];
            push_pkt(3'b101);
            do_req(3'b101, ack, vld);
            @(negedge clk);
            checks++;
            if (ack !== 1'b1 || tx_if.tx_word !== (r == 1 ? 16'hB805 : 16'hA805)) begin
                errors++;
                $display("FAIL data_header role=%0d: ack=%b word=%h, required ack=1 word=%h",
                         r, ack, tx_if.tx_word, (r == 1 ? 16'hB805 : 16'hA805));
            end
            wait_idle(20, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL data_timeout role=%0d: packet not drained, required drained", r);
            end
        end
        low_E = 1'b0;
        role  = 1'b0;
    endtask

    task automatic test_che_stall();
        logic       ack, vld;
        logic [3:0] pat;
        int         c0;
        bit         to;
        pat = 4'b1001;
        myQValue = 16'h1234; energy = 16'h5678;
        push_pkt(3'b001);
        c0 = xfer_cnt;
        tx_if.tx_ready = 1'b0;
        do_req(3'b001, ack, vld);
        myQValue = 16'hDEAD; energy = 16'hBEEF;
        to = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tx_if.tx_ready = pat[c % 4];
            step();
            if (!busy && sb.size() == 0) begin
                to = 1'b0;
                break;
            end
        end
        tx_if.tx_ready = 1'b1;
        checks++;
        if (ack !== 1'b1 || to || xfer_cnt - c0 != 5) begin
            errors++;
            $display("FAIL che_stall: ack=%b timeout=%0d xfers=%0d, required ack=1 timeout=0 xfers=5",
                     ack, to, xfer_cnt - c0);
        end
    endtask

    task automatic test_reserved();
        logic       ack, vld;
        logic [2:0] types[2];
        types[0] = 3'b011;
        types[1] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            do_req(types[i], ack, vld);
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || err !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL reserved_err type=%b: ack=%b err=%b valid=%b, required 0 1 0",
                         types[i], ack, err, tx_if.tx_valid);
            end
            step();
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reserved_after type=%b: err=%b valid=%b busy=%b, required 0 0 0",
                         types[i], err, tx_if.tx_valid, busy);
            end
        end
    endtask

    task automatic test_hb_sat_busy();
        logic ack, vld;
        bit   to;
        int   c0;
        hopsFromSink = 16'hFFFF;
        push_pkt(3'b000);
        c0 = xfer_cnt;
        do_req(3'b000, ack, vld);
        tx_req = 1'b1;
        tx_pkt_type = 3'b000;
        @(negedge clk);
        checks++;
        if (req_ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_req_ack: ack=%b busy=%b, required ack=0 busy=1", req_ack, busy);
        end
        step();
        tx_req = 1'b0;
        wait_idle(20, to);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (to || xfer_cnt - c0 != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hb_sat_single: timeout=%0d xfers=%0d busy=%b, required 0 4 0", to, xfer_cnt - c0, busy);
        end
        hopsFromSink = 16'h0003;
    endtask

    task automatic test_reset_mid_ts();
        logic ack, vld;
        bit   to;
        int   c0;
        dst_id = 16'h0033; timeslot = 16'h0009;
        push_pkt(3'b100);
        c0 = xfer_cnt;
        do_req(3'b100, ack, vld);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (xfer_cnt - c0 >= 2) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
        end
        step();
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({tx_if.tx_valid, busy, done, err} !== 4'b0 || to || xfer_cnt - c0 != 2) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%b err=%b timeout=%0d xfers=%0d, required 0 0 0 0 0 2",
                     tx_if.tx_valid, busy, done, err, to, xfer_cnt - c0);
        end
        sb.delete();
        step();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (tx_if.tx_valid !== 1'b0 || xfer_cnt - c0 != 2) begin
            errors++;
            $display("FAIL reset_no_resume: valid=%b xfers=%0d, required 0 and 2", tx_if.tx_valid, xfer_cnt - c0);
        end

        energy = 16'h0321;
        push_pkt(3'b110);
        do_req(3'b110, ack, vld);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || tx_if.tx_word !== 16'hC004) begin
            errors++;
            $display("FAIL sos_header: ack=%b word=%h, required ack=1 word=c004", ack, tx_if.tx_word);
        end
        wait_idle(20, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL sos_timeout: packet not drained, required drained");
        end
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        test_reset();
        test_hb();
        test_data();
        test_che_stall();
        test_reserved();
        test_hb_sat_busy();
        test_reset_mid_ts();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d words, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
